// File: rtl/sd_wb_regs_v2.sv
// Wishbone register file for the SD controller: control/status registers, byte-lane writes,
// BD-RAM write sequencer and bus/hardware command arbitration. Optional macro: SD_WB_ERR_EN.
module sd_wb_regs_v2 #(
    parameter int         BD_WORD_W     = 16,
    parameter logic [7:0] RESET_CLK_DIV = 8'd0,
    parameter logic [15:0] BLOCK_SIZE   = 16'd512,
    parameter bit         BUS_4BIT      = 1'b0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [7:0]           wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic                 wb_ack_o,
`ifdef SD_WB_ERR_EN
    output logic                 wb_err_o,
`endif
    output logic [31:0]          argument_reg,
    output logic [15:0]          cmd_setting_reg,
    output logic                 new_cmd,
    output logic                 cmd_src,
    input  logic                 write_req_s,
    input  logic [15:0]          cmd_set_s,
    input  logic [31:0]          cmd_arg_s,
    output logic                 we_ack,
    input  logic [15:0]          status_reg,
    input  logic [31:0]          cmd_resp_1,
    input  logic [31:0]          cmd_resp_2,
    input  logic [31:0]          cmd_resp_3,
    input  logic [31:0]          cmd_resp_4,
    output logic [7:0]           software_reset_reg,
    output logic [15:0]          time_out_reg,
    output logic [15:0]          normal_int_signal_enable_reg,
    output logic [15:0]          error_int_signal_enable_reg,
    output logic [7:0]           clock_divider,
    input  logic [15:0]          normal_int_status_reg,
    input  logic [15:0]          error_int_status_reg,
    output logic                 normal_isr_reset,
    output logic                 error_isr_reset,
    output logic                 bd_isr_reset,
    input  logic [15:0]          Bd_Status_reg,
    input  logic [7:0]           Bd_isr_reg,
    output logic [7:0]           Bd_isr_enable_reg,
    input  logic                 bd_rx_free_i,
    input  logic                 bd_tx_free_i,
    output logic                 we_m_rx_bd,
    output logic                 we_m_tx_bd,
    output logic [BD_WORD_W-1:0] dat_in_m_rx_bd,
    output logic [BD_WORD_W-1:0] dat_in_m_tx_bd
);

    localparam int   N_BD   = 32 / BD_WORD_W;
    localparam logic LAST_K = (N_BD == 2) ? 1'b1 : 1'b0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACK    = 2'd1;
    localparam logic [1:0] S_BD_WR  = 2'd2;
    localparam logic [1:0] S_BD_ACK = 2'd3;

    logic [1:0]  r_state;
    logic        r_bd_cnt;
    logic        r_bd_tx;
    logic [31:0] r_dat;
    logic [31:0] r_argument;
    logic [15:0] r_cmd_setting;
    logic [7:0]  r_sw_reset;
    logic [15:0] r_time_out;
    logic [15:0] r_normal_int_en;
    logic [15:0] r_error_int_en;
    logic [7:0]  r_clk_div;
    logic [7:0]  r_bd_isr_en;
    logic        r_new_cmd;
    logic        r_cmd_src;
    logic        r_we_ack;
    logic        r_normal_isr_rst;
    logic        r_error_isr_rst;
    logic        r_bd_isr_rst;

    logic        w_req;
    logic        w_adr_bd_rx;
    logic        w_adr_bd_tx;
    logic        w_adr_bd;
    logic        w_access_ok;
    logic        w_wr_en;
    logic        w_rd_en;
    logic        w_hw_take;
    logic        w_bd_free;
    logic        w_bd_we;
    logic [5:0]  w_bd_lsb;
    logic [BD_WORD_W-1:0] w_bd_word;
    logic [31:0] w_rd_data;

    function automatic logic [31:0] merge32(input logic [31:0] oldVal, input logic [31:0] newVal,
                                            input logic [3:0] sel);
        logic [31:0] result;
        for (int b = 0; b < 4; b++)
            result[b*8 +: 8] = sel[b] ? newVal[b*8 +: 8] : oldVal[b*8 +: 8];
        return result;
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] oldVal, input logic [15:0] newVal,
                                            input logic [1:0] sel);
        return {sel[1] ? newVal[15:8] : oldVal[15:8], sel[0] ? newVal[7:0] : oldVal[7:0]};
    endfunction

    assign w_req       = wb_stb_i & wb_cyc_i;
    assign w_adr_bd_rx = (wb_adr_i == 8'h60);
    assign w_adr_bd_tx = (wb_adr_i == 8'h80);
    assign w_adr_bd    = w_adr_bd_rx | w_adr_bd_tx;

`ifdef SD_WB_ERR_EN
    logic       r_err_flag;
    logic [7:0] r_bd_wait;
    logic       w_mapped;

    always_comb begin
        w_mapped = 1'b0;
        case (wb_adr_i)
            8'h00, 8'h04, 8'h08, 8'h0C, 8'h1C, 8'h20, 8'h28, 8'h2C,
            8'h30, 8'h34, 8'h38, 8'h3C, 8'h4C, 8'h50, 8'h54, 8'h58,
            8'h60, 8'h64, 8'h68, 8'h6C, 8'h80: w_mapped = 1'b1;
            default:                           w_mapped = 1'b0;
        endcase
    end

    assign w_access_ok = w_mapped;
    assign wb_ack_o    = ((r_state == S_ACK) & ~r_err_flag) | (r_state == S_BD_ACK);
    assign wb_err_o    = (r_state == S_ACK) & r_err_flag;
`else
    assign w_access_ok = 1'b1;
    assign wb_ack_o    = (r_state == S_ACK) | (r_state == S_BD_ACK);
`endif

    assign w_wr_en   = (r_state == S_IDLE) & w_req & wb_we_i & ~w_adr_bd & w_access_ok;
    assign w_rd_en   = (r_state == S_IDLE) & w_req & ~wb_we_i & w_access_ok;
    // The grant pulse is still high while the requester drops its level, so it blocks a retake.
    assign w_hw_take = (r_state == S_IDLE) & ~w_req & write_req_s & ~r_we_ack;

    assign w_bd_free = r_bd_tx ? bd_tx_free_i : bd_rx_free_i;
    assign w_bd_we   = (r_state == S_BD_WR) & wb_cyc_i & w_bd_free;
    assign w_bd_lsb  = {1'b0, r_bd_cnt, 4'b0000};
    assign w_bd_word = wb_dat_i[w_bd_lsb +: BD_WORD_W];

    assign we_m_tx_bd     = w_bd_we & r_bd_tx;
    assign we_m_rx_bd     = w_bd_we & ~r_bd_tx;
    assign dat_in_m_tx_bd = ((r_state == S_BD_WR) &  r_bd_tx) ? w_bd_word : '0;
    assign dat_in_m_rx_bd = ((r_state == S_BD_WR) & ~r_bd_tx) ? w_bd_word : '0;

    always_comb begin
        w_rd_data = '0;
        case (wb_adr_i)
            8'h00:   w_rd_data = r_argument;
            8'h04:   w_rd_data = {16'd0, r_cmd_setting};
            8'h08:   w_rd_data = {16'd0, status_reg};
            8'h0C:   w_rd_data = cmd_resp_1;
            8'h1C:   w_rd_data = {30'd0, BUS_4BIT, 1'b0};
            8'h20:   w_rd_data = {16'd0, BLOCK_SIZE};
            8'h28:   w_rd_data = {24'd0, r_sw_reset};
            8'h2C:   w_rd_data = {16'd0, r_time_out};
            8'h30:   w_rd_data = {16'd0, normal_int_status_reg};
            8'h34:   w_rd_data = {16'd0, error_int_status_reg};
            8'h38:   w_rd_data = {16'd0, r_normal_int_en};
            8'h3C:   w_rd_data = {16'd0, r_error_int_en};
            8'h4C:   w_rd_data = {24'd0, r_clk_div};
            8'h50:   w_rd_data = {16'd0, Bd_Status_reg};
            8'h54:   w_rd_data = {24'd0, Bd_isr_reg};
            8'h58:   w_rd_data = {24'd0, r_bd_isr_en};
            8'h64:   w_rd_data = cmd_resp_2;
            8'h68:   w_rd_data = cmd_resp_3;
            8'h6C:   w_rd_data = cmd_resp_4;
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_bd_cnt <= 1'b0;
            r_bd_tx  <= 1'b0;
`ifdef SD_WB_ERR_EN
            r_err_flag <= 1'b0;
            r_bd_wait  <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (wb_we_i && w_adr_bd) begin
                            r_state  <= S_BD_WR;
                            r_bd_cnt <= 1'b0;
                            r_bd_tx  <= w_adr_bd_tx;
`ifdef SD_WB_ERR_EN
                            r_bd_wait <= 8'd0;
`endif
                        end else begin
                            r_state <= S_ACK;
`ifdef SD_WB_ERR_EN
                            r_err_flag <= ~w_access_ok;
`endif
                        end
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
`ifdef SD_WB_ERR_EN
                    r_err_flag <= 1'b0;
`endif
                end
                S_BD_WR: begin
                    // Dropping cyc abandons the descriptor; words already strobed are not undone.
                    if (!wb_cyc_i) begin
                        r_state  <= S_IDLE;
                        r_bd_cnt <= 1'b0;
                    end else if (w_bd_free) begin
                        if (r_bd_cnt == LAST_K) begin
                            r_state  <= S_BD_ACK;
                            r_bd_cnt <= 1'b0;
                        end else begin
                            r_bd_cnt <= r_bd_cnt + 1'b1;
                        end
`ifdef SD_WB_ERR_EN
                    end else if (r_bd_wait == 8'hFF) begin
                        r_state    <= S_ACK;
                        r_err_flag <= 1'b1;
                        r_bd_cnt   <= 1'b0;
                    end else begin
                        r_bd_wait <= r_bd_wait + 8'd1;
`endif
                    end
                end
                S_BD_ACK: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_argument      <= '0;
            r_cmd_setting   <= '0;
            r_sw_reset      <= '0;
            r_time_out      <= '0;
            r_normal_int_en <= '0;
            r_error_int_en  <= '0;
            r_clk_div       <= RESET_CLK_DIV;
            r_bd_isr_en     <= '0;
        end else if (w_wr_en) begin
            case (wb_adr_i)
                8'h00: r_argument      <= merge32(r_argument, wb_dat_i, wb_sel_i);
                8'h04: r_cmd_setting   <= merge16(r_cmd_setting, wb_dat_i[15:0], wb_sel_i[1:0]);
                8'h28: r_sw_reset      <= wb_sel_i[0] ? wb_dat_i[7:0] : r_sw_reset;
                8'h2C: r_time_out      <= merge16(r_time_out, wb_dat_i[15:0], wb_sel_i[1:0]);
                8'h38: r_normal_int_en <= merge16(r_normal_int_en, wb_dat_i[15:0], wb_sel_i[1:0]);
                8'h3C: r_error_int_en  <= merge16(r_error_int_en, wb_dat_i[15:0], wb_sel_i[1:0]);
                8'h4C: r_clk_div       <= wb_sel_i[0] ? wb_dat_i[7:0] : r_clk_div;
                8'h58: r_bd_isr_en     <= wb_sel_i[0] ? wb_dat_i[7:0] : r_bd_isr_en;
                default: ;
            endcase
        end else if (w_hw_take) begin
            r_argument    <= cmd_arg_s;
            r_cmd_setting <= cmd_set_s;
        end
    end

    // Pulses are set on the accepting edge so they line up with the ack cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_new_cmd        <= 1'b0;
            r_cmd_src        <= 1'b0;
            r_we_ack         <= 1'b0;
            r_normal_isr_rst <= 1'b0;
            r_error_isr_rst  <= 1'b0;
            r_bd_isr_rst     <= 1'b0;
            r_dat            <= '0;
        end else begin
            r_new_cmd        <= (w_wr_en && wb_adr_i == 8'h00) || w_hw_take;
            r_we_ack         <= w_hw_take;
            r_normal_isr_rst <= w_wr_en && (wb_adr_i == 8'h30);
            r_error_isr_rst  <= w_wr_en && (wb_adr_i == 8'h34);
            r_bd_isr_rst     <= w_wr_en && (wb_adr_i == 8'h54);
            if (w_wr_en && wb_adr_i == 8'h00)
                r_cmd_src <= 1'b0;
            else if (w_hw_take)
                r_cmd_src <= 1'b1;
            if (w_rd_en)
                r_dat <= w_rd_data;
        end
    end

    assign wb_dat_o                     = r_dat;
    assign argument_reg                 = r_argument;
    assign cmd_setting_reg              = r_cmd_setting;
    assign new_cmd                      = r_new_cmd;
    assign cmd_src                      = r_cmd_src;
    assign we_ack                       = r_we_ack;
    assign software_reset_reg           = r_sw_reset;
    assign time_out_reg                 = r_time_out;
    assign normal_int_signal_enable_reg = r_normal_int_en;
    assign error_int_signal_enable_reg  = r_error_int_en;
    assign clock_divider                = r_clk_div;
    assign normal_isr_reset             = r_normal_isr_rst;
    assign error_isr_reset              = r_error_isr_rst;
    assign bd_isr_reset                 = r_bd_isr_rst;
    assign Bd_isr_enable_reg            = r_bd_isr_en;

endmodule

// File: tb/tb_sd_wb_regs_v2.sv
// Directed bench for sd_wb_regs_v2 (default parameters; SD_WB_ERR_EN selects the error-response checks).
module tb_sd_wb_regs_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
`ifdef SD_WB_ERR_EN
    logic        wb_err_o;
`endif
    logic [31:0] argument_reg;
    logic [15:0] cmd_setting_reg;
    logic        new_cmd, cmd_src, write_req_s, we_ack;
    logic [15:0] cmd_set_s;
    logic [31:0] cmd_arg_s;
    logic [15:0] status_reg;
    logic [31:0] cmd_resp_1, cmd_resp_2, cmd_resp_3, cmd_resp_4;
    logic [7:0]  software_reset_reg;
    logic [15:0] time_out_reg, normal_int_signal_enable_reg, error_int_signal_enable_reg;
    logic [7:0]  clock_divider;
    logic [15:0] normal_int_status_reg, error_int_status_reg;
    logic        normal_isr_reset, error_isr_reset, bd_isr_reset;
    logic [15:0] Bd_Status_reg;
    logic [7:0]  Bd_isr_reg, Bd_isr_enable_reg;
    logic        bd_rx_free_i, bd_tx_free_i, we_m_rx_bd, we_m_tx_bd;
    logic [15:0] dat_in_m_rx_bd, dat_in_m_tx_bd;

    int checks = 0;
    int errors = 0;
    int bdIsrPulses = 0, nIsrPulses = 0, eIsrPulses = 0, weAckPulses = 0;
    logic [33:0] cmdLog[$];
    logic [15:0] txLog[$];
    logic [15:0] rxLog[$];

    sd_wb_regs_v2 dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
`ifdef SD_WB_ERR_EN
        .wb_err_o(wb_err_o),
`endif
        .argument_reg(argument_reg), .cmd_setting_reg(cmd_setting_reg), .new_cmd(new_cmd), .cmd_src(cmd_src),
        .write_req_s(write_req_s), .cmd_set_s(cmd_set_s), .cmd_arg_s(cmd_arg_s), .we_ack(we_ack),
        .status_reg(status_reg), .cmd_resp_1(cmd_resp_1), .cmd_resp_2(cmd_resp_2), .cmd_resp_3(cmd_resp_3),
        .cmd_resp_4(cmd_resp_4), .software_reset_reg(software_reset_reg), .time_out_reg(time_out_reg),
        .normal_int_signal_enable_reg(normal_int_signal_enable_reg),
        .error_int_signal_enable_reg(error_int_signal_enable_reg), .clock_divider(clock_divider),
        .normal_int_status_reg(normal_int_status_reg), .error_int_status_reg(error_int_status_reg),
        .normal_isr_reset(normal_isr_reset), .error_isr_reset(error_isr_reset), .bd_isr_reset(bd_isr_reset),
        .Bd_Status_reg(Bd_Status_reg), .Bd_isr_reg(Bd_isr_reg), .Bd_isr_enable_reg(Bd_isr_enable_reg),
        .bd_rx_free_i(bd_rx_free_i), .bd_tx_free_i(bd_tx_free_i), .we_m_rx_bd(we_m_rx_bd),
        .we_m_tx_bd(we_m_tx_bd), .dat_in_m_rx_bd(dat_in_m_rx_bd), .dat_in_m_tx_bd(dat_in_m_tx_bd)
    );

    always #5 clk = ~clk;

    // Records every strobe/pulse seen mid-cycle so widths and ordering can be checked afterwards.
    always @(negedge clk) begin
        if (new_cmd) cmdLog.push_back({we_ack, cmd_src, argument_reg});
        if (we_m_tx_bd) txLog.push_back(dat_in_m_tx_bd);
        if (we_m_rx_bd) rxLog.push_back(dat_in_m_rx_bd);
        if (bd_isr_reset) bdIsrPulses++;
        if (normal_isr_reset) nIsrPulses++;
        if (error_isr_reset) eIsrPulses++;
        if (we_ack) weAckPulses++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at posedge+1 with the bus idle; returns at posedge+1 with the bus idle again.
    task automatic applyStimulus(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                                 input logic we, output logic [31:0] rdata, output int waits,
                                 output bit gotAck, output bit gotErr);
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        rdata = '0; waits = 0; gotAck = 1'b0; gotErr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wb_ack_o) begin gotAck = 1'b1; rdata = wb_dat_o; break; end
`ifdef SD_WB_ERR_EN
            if (wb_err_o) begin gotErr = 1'b1; break; end
`endif
            waits++;
        end
        @(posedge clk); #1;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    logic [31:0] rd;
    int          waits;
    bit          gotAck, gotErr, seen, strobeAtAck;
    int          base, bdBase, nBase, eBase, weBase, ackCount, bdAckWait;

    initial begin
        rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 0; wb_cyc_i = 0; wb_stb_i = 0;
        write_req_s = 0; cmd_set_s = '0; cmd_arg_s = '0;
        status_reg = 16'hBEEF; cmd_resp_1 = 32'h1111_0001; cmd_resp_2 = 32'h2222_0002;
        cmd_resp_3 = 32'h3333_0003; cmd_resp_4 = 32'h4444_0004;
        normal_int_status_reg = 16'h0101; error_int_status_reg = 16'h0202;
        Bd_Status_reg = 16'h0303; Bd_isr_reg = 8'h04;
        bd_rx_free_i = 0; bd_tx_free_i = 0;

        repeat (3) @(posedge clk); #1;
        checkOutput("rst_argument", 64'(argument_reg), 64'h0);
        checkOutput("rst_clock_divider", 64'(clock_divider), 64'h0);
        checkOutput("rst_controls", 64'({new_cmd, cmd_src, we_ack, wb_ack_o, we_m_rx_bd, we_m_tx_bd,
                                         bd_isr_reset}), 64'h0);
        checkOutput("rst_regs", 64'({cmd_setting_reg, time_out_reg, Bd_isr_enable_reg, software_reset_reg}), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(8'h4C, 32'h0, 4'hF, 1'b0, rd, waits, gotAck, gotErr);
        checkOutput("rd_clkdiv_reset", 64'({gotAck, rd}), 64'({1'b1, 32'h0000_0000}));
        checkOutput("rd_latency", 64'(waits), 64'd1);
        applyStimulus(8'h20, 32'h0, 4'hF, 1'b0, rd, waits, gotAck, gotErr);
        checkOutput("rd_block_size", 64'({gotAck, rd}), 64'({1'b1, 32'h0000_0200}));

        applyStimulus(8'h2C, 32'h0000_1234, 4'hF, 1'b1, rd, waits, gotAck, gotErr);
        applyStimulus(8'h2C, 32'hAABB_CCDD, 4'b0001, 1'b1, rd, waits, gotAck, gotErr);
        applyStimulus(8'h2C, 32'h0, 4'hF, 1'b0, rd, waits, gotAck, gotErr);
        checkOutput("byte_lane_readback", 64'(rd), 64'h0000_12DD);
        checkOutput("byte_lane_port", 64'(time_out_reg), 64'h12DD);

        applyStimulus(8'h4C, 32'h0000_005A, 4'hF, 1'b1, rd, waits, gotAck, gotErr);
        checkOutput("clkdiv_port", 64'(clock_divider), 64'h5A);
        applyStimulus(8'h08, 32'h0, 4'hF, 1'b0, rd, waits, gotAck, gotErr);
        checkOutput("rd_status", 64'(rd), 64'h0000_BEEF);
        applyStimulus(8'h68, 32'h0, 4'hF, 1'b0, rd, waits, gotAck, gotErr);
        checkOutput("rd_resp3", 64'(rd), 64'h3333_0003);
        applyStimulus(8'h1C, 32'h0, 4'hF, 1'b0, rd, waits, gotAck, gotErr);
        checkOutput("rd_controller", 64'(rd), 64'h0);
        applyStimulus(8'h60, 32'h0, 4'hF, 1'b0, rd, waits, gotAck, gotErr);
        checkOutput("rd_bd_window", 64'({gotAck, rd}), 64'({1'b1, 32'h0}));

        bd_tx_free_i = 1'b0;
        wb_adr_i = 8'h80; wb_dat_i = 32'h8765_4321; wb_sel_i = 4'h0; wb_we_i = 1;
        wb_stb_i = 1; wb_cyc_i = 1;
        repeat (4) @(posedge clk); #1;
        checkOutput("bd_no_strobe_while_busy", 64'(txLog.size()), 64'd0);
        bd_tx_free_i = 1'b1;
        gotAck = 0; strobeAtAck = 0; bdAckWait = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_ack_o) begin gotAck = 1; strobeAtAck = we_m_tx_bd; break; end
            bdAckWait++;
        end
        @(posedge clk); #1;
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0; bd_tx_free_i = 0;
        checkOutput("bd_ack", 64'({gotAck, strobeAtAck}), 64'({1'b1, 1'b0}));
        checkOutput("bd_ack_after_words", 64'(bdAckWait), 64'd2);
        checkOutput("bd_word_count", 64'(txLog.size()), 64'd2);
        if (txLog.size() == 2) begin
            checkOutput("bd_word0", 64'(txLog[0]), 64'h4321);
            checkOutput("bd_word1", 64'(txLog[1]), 64'h8765);
        end
        checkOutput("bd_rx_untouched", 64'(rxLog.size()), 64'd0);

        base = cmdLog.size();
        applyStimulus(8'h04, 32'h0000_55AA, 4'hF, 1'b1, rd, waits, gotAck, gotErr);
        checkOutput("cmd_setting_no_pulse", 64'({cmd_setting_reg, 16'(cmdLog.size() - base)}),
                    64'({16'h55AA, 16'd0}));

        weBase = weAckPulses;
        cmd_arg_s = 32'hDEAD_BEEF; cmd_set_s = 16'h0A1B; write_req_s = 1'b1;
        applyStimulus(8'h00, 32'h0000_0011, 4'hF, 1'b1, rd, waits, gotAck, gotErr);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (we_ack) begin seen = 1; break; end
        end
        @(posedge clk); #1;
        write_req_s = 1'b0;
        repeat (2) @(posedge clk); #1;
        checkOutput("arb_grant_seen", 64'(seen), 64'd1);
        checkOutput("arb_cmd_count", 64'(cmdLog.size() - base), 64'd2);
        if (cmdLog.size() - base == 2) begin
            checkOutput("arb_bus_first", 64'(cmdLog[base]), 64'({1'b0, 1'b0, 32'h0000_0011}));
            checkOutput("arb_hw_second", 64'(cmdLog[base + 1]), 64'({1'b1, 1'b1, 32'hDEAD_BEEF}));
        end
        checkOutput("arb_we_ack_once", 64'(weAckPulses - weBase), 64'd1);
        checkOutput("arb_final_state", 64'({cmd_src, cmd_setting_reg}), 64'({1'b1, 16'h0A1B}));

        bdBase = bdIsrPulses; nBase = nIsrPulses; eBase = eIsrPulses;
        applyStimulus(8'h54, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, waits, gotAck, gotErr);
        @(posedge clk); #1;
        checkOutput("bd_isr_pulse", 64'({8'(bdIsrPulses - bdBase), 8'(nIsrPulses - nBase), 8'(eIsrPulses - eBase)}),
                    64'({8'd1, 8'd0, 8'd0}));
        applyStimulus(8'h34, 32'h0, 4'hF, 1'b1, rd, waits, gotAck, gotErr);
        @(posedge clk); #1;
        checkOutput("err_isr_pulse", 64'({8'(bdIsrPulses - bdBase), 8'(nIsrPulses - nBase), 8'(eIsrPulses - eBase)}),
                    64'({8'd1, 8'd0, 8'd1}));

        applyStimulus(8'h70, 32'h0, 4'hF, 1'b0, rd, waits, gotAck, gotErr);
`ifdef SD_WB_ERR_EN
        checkOutput("unmapped_err", 64'({gotErr, gotAck}), 64'({1'b1, 1'b0}));
`else
        checkOutput("unmapped_read", 64'({gotAck, rd}), 64'({1'b1, 32'h0}));
`endif

        bd_rx_free_i = 1'b0;
        wb_adr_i = 8'h60; wb_dat_i = 32'h1111_2222; wb_sel_i = 4'hF; wb_we_i = 1;
        wb_stb_i = 1; wb_cyc_i = 1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_regs", 64'({argument_reg, clock_divider, cmd_setting_reg}), 64'h0);
        checkOutput("midrst_controls", 64'({cmd_src, wb_ack_o, we_m_rx_bd, time_out_reg}), 64'h0);
        bd_rx_free_i = 1'b1;
        ackCount = 0;
        repeat (3) begin @(negedge clk); if (wb_ack_o) ackCount++; end
        @(posedge clk); #1;
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (wb_ack_o) ackCount++; end
        @(posedge clk); #1;
        checkOutput("midrst_no_ack", 64'(ackCount), 64'd0);
        checkOutput("midrst_no_rx_strobe", 64'(rxLog.size()), 64'd0);
        applyStimulus(8'h4C, 32'h0, 4'hF, 1'b0, rd, waits, gotAck, gotErr);
        checkOutput("post_rst_clkdiv", 64'({gotAck, rd}), 64'({1'b1, 32'h0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
